// File: rtl/input_data_capture.sv
// Multi-channel trigger capture: ring buffer with pre-trigger history and flow-controlled readout.
// Define TRG_TIMESTAMP_EN to add a free-running cycle counter latched into Trig_Timestamp at trigger.
module input_data_capture #(
  parameter int G_CHANNELS   = 4,
  parameter int G_DATA_WIDTH = 12,
  parameter int G_DEPTH      = 256,
  parameter int G_PRETRIG    = 64
) (
  input  logic                                   Clock,
  input  logic                                   Reset,
  input  logic                                   Data_Valid,
  input  logic [G_CHANNELS*G_DATA_WIDTH-1:0]     Input_Data,
  input  logic [G_DATA_WIDTH-1:0]                TRG_Threshold,
  input  logic [G_CHANNELS-1:0]                  TRG_Mask,
  input  logic                                   Arm,
  input  logic                                   Rd_Ready,
  output logic                                   Busy,
  output logic [G_CHANNELS-1:0]                  TRG_Detect_Vector,
  output logic                                   Rd_Valid,
  output logic [G_CHANNELS*(G_DATA_WIDTH+1)-1:0] Q,
  output logic                                   Rd_Last,
  output logic [31:0]                            Trig_Timestamp
);

  localparam int AW       = $clog2(G_DEPTH);
  localparam int CW       = AW + 1;
  localparam int SW       = G_CHANNELS * G_DATA_WIDTH;
  localparam int QW       = G_CHANNELS * (G_DATA_WIDTH + 1);
  localparam int POST_LEN = G_DEPTH - G_PRETRIG;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_ARMED,
    S_POST,
    S_READOUT
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   trig_addr_q;
  logic [AW-1:0]   rd_addr_q;
  logic [CW-1:0]   cap_cnt_q;
  logic [CW-1:0]   rd_cnt_q;
  logic [SW-1:0]   mem [G_DEPTH];
  logic [SW-1:0]   rd_data_q;
  logic            mem_valid_q;
  logic            mem_mark_q;
  logic            mem_last_q;
  logic [G_CHANNELS-1:0] det_q;
  logic [G_CHANNELS-1:0] cross_d;
  logic [QW-1:0]   q_q;
  logic [QW-1:0]   q_d;
  logic            rd_valid_q;
  logic            rd_last_q;
  logic            capture_we_d;
  logic            trig_d;
  logic            out_fire_d;
  logic            mem_move_d;
  logic            issue_d;

  genvar gi;
  generate
    for (gi = 0; gi < G_CHANNELS; gi++) begin : g_ch
      logic [G_DATA_WIDTH-1:0] smp_d;
      logic [G_DATA_WIDTH-1:0] prev_q;

      assign smp_d       = Input_Data[gi*G_DATA_WIDTH +: G_DATA_WIDTH];
      assign cross_d[gi] = Data_Valid && (smp_d >= TRG_Threshold) && (prev_q < TRG_Threshold);
      assign q_d[gi*(G_DATA_WIDTH+1) +: G_DATA_WIDTH+1] =
             {mem_mark_q, rd_data_q[gi*G_DATA_WIDTH +: G_DATA_WIDTH]};

      // History follows every valid sample, whatever the capture state.
      always_ff @(posedge Clock) begin
        if (Reset) begin
          prev_q <= '0;
        end else if (Data_Valid) begin
          prev_q <= smp_d;
        end
      end
    end
  endgenerate

  assign capture_we_d = Data_Valid &&
                        (state_q == S_PREFILL || state_q == S_ARMED || state_q == S_POST);
  assign trig_d       = (state_q == S_ARMED) && (|(cross_d & TRG_Mask));

  // Two-stage read pipeline: RAM output register, then the Q output register.
  assign out_fire_d = rd_valid_q && Rd_Ready;
  assign mem_move_d = mem_valid_q && (!rd_valid_q || Rd_Ready);
  assign issue_d    = (state_q == S_READOUT) && (rd_cnt_q != CW'(G_DEPTH)) &&
                      (!mem_valid_q || mem_move_d);

  always_ff @(posedge Clock) begin
    if (capture_we_d) begin
      mem[wr_ptr_q] <= Input_Data;
    end
    if (issue_d) begin
      rd_data_q <= mem[rd_addr_q];
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      trig_addr_q <= '0;
      rd_addr_q   <= '0;
      cap_cnt_q   <= '0;
      rd_cnt_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_mark_q  <= 1'b0;
      mem_last_q  <= 1'b0;
      det_q       <= '0;
      q_q         <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      det_q <= cross_d;
      if (capture_we_d) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (Arm) begin
            state_q   <= S_PREFILL;
            cap_cnt_q <= '0;
          end
        end
        S_PREFILL: begin
          if (Data_Valid) begin
            if (cap_cnt_q == CW'(G_PRETRIG - 1)) begin
              state_q   <= S_ARMED;
              cap_cnt_q <= '0;
            end else begin
              cap_cnt_q <= cap_cnt_q + CW'(1);
            end
          end
        end
        S_ARMED: begin
          // The trigger sample itself is the first post-trigger sample.
          if (trig_d) begin
            trig_addr_q <= wr_ptr_q;
            rd_addr_q   <= wr_ptr_q - AW'(G_PRETRIG);
            rd_cnt_q    <= '0;
            cap_cnt_q   <= CW'(1);
            state_q     <= (POST_LEN == 1) ? S_READOUT : S_POST;
          end
        end
        S_POST: begin
          if (Data_Valid) begin
            if (cap_cnt_q == CW'(POST_LEN - 1)) begin
              state_q <= S_READOUT;
            end else begin
              cap_cnt_q <= cap_cnt_q + CW'(1);
            end
          end
        end
        S_READOUT: begin
          if (issue_d) begin
            rd_addr_q   <= rd_addr_q + AW'(1);
            rd_cnt_q    <= rd_cnt_q + CW'(1);
            mem_mark_q  <= (rd_addr_q == trig_addr_q);
            mem_last_q  <= (rd_cnt_q == CW'(G_DEPTH - 1));
            mem_valid_q <= 1'b1;
          end else if (mem_move_d) begin
            mem_valid_q <= 1'b0;
          end
          if (mem_move_d) begin
            q_q        <= q_d;
            rd_valid_q <= 1'b1;
            rd_last_q  <= mem_last_q;
          end else if (out_fire_d) begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
          end
          if (out_fire_d && rd_last_q) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef TRG_TIMESTAMP_EN
  logic [31:0] cyc_q;
  logic [31:0] ts_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cyc_q <= '0;
      ts_q  <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (trig_d) begin
        ts_q <= cyc_q;
      end
    end
  end

  assign Trig_Timestamp = ts_q;
`else
  assign Trig_Timestamp = '0;
`endif

  assign Busy              = (state_q != S_IDLE);
  assign TRG_Detect_Vector = det_q;
  assign Rd_Valid          = rd_valid_q;
  assign Q                 = q_q;
  assign Rd_Last           = rd_last_q;

endmodule
